iir2_ctrl: RTL and testbench

//  Sequencer in front of one iir2 instance. Accepts samples on a valid/ready stream and paces f_data_in_valid to the
//  iir2 multiplier latency. Applies coefficient updates only between samples and drives the iir2 clear pulse.

---
 rtl/iir2_ctrl_if.sv | 21 ++
 rtl/iir2_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_iir2_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir2_ctrl_if.sv
// ---------------------------------------------------------------------------
// iir2_ctrl_if
//   Generic valid/ready sample stream used on both sides of iir2_ctrl.
//   Signals:
//     valid  producer -> consumer   sample present
//     ready  consumer -> producer   sample accepted when valid & ready
//     data   producer -> consumer   sample value (W bits, two's complement)
//   Modports:
//     master  producer side (drives valid/data, observes ready)
//     slave   consumer side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface iir2_ctrl_if #(
    parameter int W = 32
) ();
    logic                valid;
    logic                ready;
    logic signed [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/iir2_ctrl.sv
// ---------------------------------------------------------------------------
// iir2_ctrl
//   Sequencer in front of one iir2 filter instance. Accepts input samples on
//   a valid/ready stream, paces them into the filter no faster than one every
//   SAMPLE_GAP cycles, applies coefficient updates only between samples,
//   drives the filter clear pulse and buffers each filter output in a
//   one-entry register for a backpressured consumer.
//
//   Optional feature (compile-time macro IIR2_CTRL_WARMUP_EN):
//     discard the first WARMUP filter outputs after reset or a soft clear.
//
//   Ports:
//     clk, rstx                 clock, asynchronous active-low reset
//     soft_clear                pulse: abort and clear the filter state
//     coeff_update              pulse: capture cfg_* into the shadow regs
//     cfg_is_1st_order          order select to shadow
//     cfg_coeff_a1/a2           coefficients to shadow
//     s   (slave stream)        input samples   (width DDY+DPR+CPR+1)
//     m   (master stream)       output samples  (width DDY+DPR+3)
//     f_clear                   to iir2 clear
//     f_is_1st_order            to iir2 order select
//     f_coeff_a1/a2             to iir2 coefficients
//     f_data_in_valid/f_data_in to iir2 sample input
//     f_data_out_valid/f_data_out from iir2 sample output
//     busy                      FSM active or coefficient update pending
// ---------------------------------------------------------------------------
module iir2_ctrl #(
    parameter int CPR        = 8,
    parameter int CDY        = 1,
    parameter int DPR        = 25,
    parameter int DDY        = 4,
    parameter int SAMPLE_GAP = 18,
    parameter int WARMUP     = 2
) (
    input  logic                          clk,
    input  logic                          rstx,
    input  logic                          soft_clear,
    input  logic                          coeff_update,
    input  logic                          cfg_is_1st_order,
    input  logic signed [CDY+CPR:0]       cfg_coeff_a1,
    input  logic signed [CDY+CPR:0]       cfg_coeff_a2,
    iir2_ctrl_if.slave                    s,
    iir2_ctrl_if.master                   m,
    output logic                          f_clear,
    output logic                          f_is_1st_order,
    output logic signed [CDY+CPR:0]       f_coeff_a1,
    output logic signed [CDY+CPR:0]       f_coeff_a2,
    output logic                          f_data_in_valid,
    output logic signed [DDY+DPR+CPR:0]   f_data_in,
    input  logic                          f_data_out_valid,
    input  logic signed [DDY+DPR+2:0]     f_data_out,
    output logic                          busy
);
    localparam int CW  = CDY + CPR + 1;
    localparam int DIW = DDY + DPR + CPR + 1;
    localparam int DOW = DDY + DPR + 3;

    if (SAMPLE_GAP < 3 || SAMPLE_GAP > 255 || WARMUP < 0 || WARMUP > 255) begin : g_bad_param
        $error("iir2_ctrl: SAMPLE_GAP must be 3..255 and WARMUP 0..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_CLR  = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_gap_cnt;
    logic                  r_coeff_pend;

    logic                  r_sh_1st;
    logic signed [CW-1:0]  r_sh_a1;
    logic signed [CW-1:0]  r_sh_a2;

    logic                  r_f_clear;
    logic                  r_f_1st;
    logic signed [CW-1:0]  r_f_a1;
    logic signed [CW-1:0]  r_f_a2;
    logic                  r_f_vld;
    logic signed [DIW-1:0] r_f_data;

    logic                  r_m_valid;
    logic signed [DOW-1:0] r_m_data;

    logic                  w_buf_free;
    logic                  w_s_ready;
    logic                  w_issue;
    logic                  w_apply;
    logic                  w_out_ok;
    logic                  w_capture;
    logic                  w_warm_busy;

    // A new sample may only be issued when the output buffer is empty or is
    // being drained this cycle; that guarantees its filter result, which
    // arrives a fixed latency later, always finds a free buffer.
    assign w_buf_free = ~r_m_valid | m.ready;
    assign w_s_ready  = (r_state == S_IDLE) & ~r_coeff_pend & ~soft_clear & w_buf_free;
    assign w_issue    = s.valid & w_s_ready;
    assign w_apply    = (r_state == S_IDLE) & r_coeff_pend & ~soft_clear;

    // Filter results are ignored while clearing and in the cycle a clear is
    // requested (the buffer is flushed on that edge anyway).
    assign w_out_ok   = f_data_out_valid & (r_state != S_CLR) & ~soft_clear;

`ifdef IIR2_CTRL_WARMUP_EN
    logic [7:0] r_warm;

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            r_warm <= 8'(WARMUP);
        end else if (r_state == S_CLR) begin
            r_warm <= 8'(WARMUP);
        end else if (f_data_out_valid && r_warm != 8'd0) begin
            r_warm <= r_warm - 8'd1;
        end
    end

    assign w_warm_busy = (r_warm != 8'd0);
    assign w_capture   = w_out_ok & ~w_warm_busy;
`else
    assign w_warm_busy = 1'b0;
    assign w_capture   = w_out_ok;
`endif

    // Shadow coefficient registers; a second update before apply overwrites.
    always_ff @(posedge clk) begin
        if (coeff_update) begin
            r_sh_1st <= cfg_is_1st_order;
            r_sh_a1  <= cfg_coeff_a1;
            r_sh_a2  <= cfg_coeff_a2;
        end
    end

    // Sequencer FSM with registered filter-side outputs.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= 8'd0;
            r_coeff_pend <= 1'b0;
            r_f_clear    <= 1'b0;
            r_f_1st      <= 1'b0;
            r_f_a1       <= '0;
            r_f_a2       <= '0;
            r_f_vld      <= 1'b0;
            r_f_data     <= '0;
        end else begin
            r_f_vld   <= 1'b0;
            r_f_clear <= 1'b0;

            if (soft_clear) begin
                // Clear wins over everything; held high it keeps us in S_CLR.
                r_state   <= S_CLR;
                r_gap_cnt <= 8'd0;
                r_f_clear <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_coeff_pend) begin
                            r_f_1st <= r_sh_1st;
                            r_f_a1  <= r_sh_a1;
                            r_f_a2  <= r_sh_a2;
                        end else if (w_issue) begin
                            r_f_data  <= s.data;
                            r_f_vld   <= 1'b1;
                            r_gap_cnt <= 8'(SAMPLE_GAP - 1);
                            r_state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                        if (r_gap_cnt == 8'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_CLR: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end

            // A fresh update in the apply cycle stays pending for the next one.
            r_coeff_pend <= coeff_update | (r_coeff_pend & ~w_apply);
        end
    end

    // One-entry output buffer; flushed by a clear.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (soft_clear || r_state == S_CLR) begin
            r_m_valid <= 1'b0;
        end else if (w_capture) begin
            r_m_valid <= 1'b1;
            r_m_data  <= f_data_out;
        end else if (m.ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s.ready         = w_s_ready;
    assign m.valid         = r_m_valid;
    assign m.data          = r_m_data;
    assign f_clear         = r_f_clear;
    assign f_is_1st_order  = r_f_1st;
    assign f_coeff_a1      = r_f_a1;
    assign f_coeff_a2      = r_f_a2;
    assign f_data_in_valid = r_f_vld;
    assign f_data_in       = r_f_data;
    assign busy            = (r_state != S_IDLE) | r_coeff_pend | w_warm_busy;

endmodule

// File: tb/tb_iir2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iir2_ctrl
//   Directed bench for iir2_ctrl with a small behavioural stand-in for the
//   iir2 filter: one cycle latency, y = (x + x_prev) >> CPR, state zeroed by
//   f_clear. With a constant input of 38'h100 this yields 1, 2, 2, ...
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iir2_ctrl;
    localparam int CPR = 8;
    localparam int CDY = 1;
    localparam int DPR = 25;
    localparam int DDY = 4;
    localparam int GAP = 18;
    localparam int CW  = CDY + CPR + 1;
    localparam int DIW = DDY + DPR + CPR + 1;
    localparam int DOW = DDY + DPR + 3;

`ifdef IIR2_CTRL_WARMUP_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rstx = 1'b0;
    logic                  soft_clear;
    logic                  coeff_update;
    logic                  cfg_is_1st_order;
    logic signed [CW-1:0]  cfg_coeff_a1;
    logic signed [CW-1:0]  cfg_coeff_a2;
    logic                  f_clear;
    logic                  f_is_1st_order;
    logic signed [CW-1:0]  f_coeff_a1;
    logic signed [CW-1:0]  f_coeff_a2;
    logic                  f_data_in_valid;
    logic signed [DIW-1:0] f_data_in;
    logic                  f_data_out_valid;
    logic signed [DOW-1:0] f_data_out;
    logic                  busy;

    iir2_ctrl_if #(.W(DIW)) s_if ();
    iir2_ctrl_if #(.W(DOW)) m_if ();

    always #5 clk = ~clk;

    iir2_ctrl #(
        .CPR(CPR), .CDY(CDY), .DPR(DPR), .DDY(DDY), .SAMPLE_GAP(GAP), .WARMUP(2)
    ) dut (
        .clk              (clk),
        .rstx             (rstx),
        .soft_clear       (soft_clear),
        .coeff_update     (coeff_update),
        .cfg_is_1st_order (cfg_is_1st_order),
        .cfg_coeff_a1     (cfg_coeff_a1),
        .cfg_coeff_a2     (cfg_coeff_a2),
        .s                (s_if),
        .m                (m_if),
        .f_clear          (f_clear),
        .f_is_1st_order   (f_is_1st_order),
        .f_coeff_a1       (f_coeff_a1),
        .f_coeff_a2       (f_coeff_a2),
        .f_data_in_valid  (f_data_in_valid),
        .f_data_in        (f_data_in),
        .f_data_out_valid (f_data_out_valid),
        .f_data_out       (f_data_out),
        .busy             (busy)
    );

    // Filter stand-in
    logic signed [DIW-1:0] x_prev;
    logic signed [DIW:0]   w_sum;
    assign w_sum = {f_data_in[DIW-1], f_data_in} + {x_prev[DIW-1], x_prev};

    always @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            f_data_out_valid <= 1'b0;
            f_data_out       <= '0;
            x_prev           <= '0;
        end else begin
            f_data_out_valid <= f_data_in_valid & ~f_clear;
            if (f_clear) begin
                x_prev <= '0;
            end else if (f_data_in_valid) begin
                x_prev     <= f_data_in;
                f_data_out <= DOW'(w_sum >>> CPR);
            end
        end
    end

    // Cycle counter and record of accepted output samples
    int                    cyc = 0;
    logic signed [DOW-1:0] q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_if.valid && m_if.ready) q.push_back(m_if.data);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_issue(input string tag, output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (f_data_in_valid) begin
                found = 1'b1;
                t = cyc;
            end
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int t0, t1, t2, tb, tb2, tc, td;
    logic signed [DOW-1:0] exp_q[$];

    initial begin
        soft_clear       = 1'b0;
        coeff_update     = 1'b0;
        cfg_is_1st_order = 1'b0;
        cfg_coeff_a1     = '0;
        cfg_coeff_a2     = '0;
        s_if.valid       = 1'b0;
        s_if.data        = '0;
        m_if.ready       = 1'b0;
        rstx             = 1'b0;

        // Reset state
        tick(3);
        chk("rst_f_vld",   64'(f_data_in_valid), 64'd0);
        chk("rst_f_clear", 64'(f_clear),         64'd0);
        chk("rst_m_valid", 64'(m_if.valid),      64'd0);
        chk("rst_m_data",  64'(m_if.data),       64'd0);
        chk("rst_f_1st",   64'(f_is_1st_order),  64'd0);
        chk("rst_f_a1",    64'(f_coeff_a1),      64'd0);
        chk("rst_f_a2",    64'(f_coeff_a2),      64'd0);
        chk("rst_busy",    64'(busy),            64'(RST_BUSY));
        rstx = 1'b1;
        tick(1);
        chk("rst_s_ready", 64'(s_if.ready), 64'd1);

        // Select 1st order, a1=a2=0
        cfg_is_1st_order = 1'b1;
        coeff_update     = 1'b1;
        tick(1);
        coeff_update = 1'b0;
        chk("cfg_pend_busy",  64'(busy),       64'd1);
        chk("cfg_pend_ready", 64'(s_if.ready), 64'd0);
        tick(1);
        chk("cfg_applied_1st", 64'(f_is_1st_order), 64'd1);
        chk("cfg_ready_again", 64'(s_if.ready),     64'd1);

        // Pacing with s_valid held high
        q.delete();
        s_if.data  = 38'h100;
        s_if.valid = 1'b1;
        m_if.ready = 1'b1;
        wait_issue("pace_issue1", t0);
        wait_issue("pace_issue2", t1);
        chk("pace_gap1", 64'(t1 - t0), 64'd18);
        wait_issue("pace_issue3", t2);
        s_if.valid = 1'b0;
        chk("pace_gap2", 64'(t2 - t1), 64'd18);
        tick(5);
`ifdef IIR2_CTRL_WARMUP_EN
        exp_q = '{32'sd2};
`else
        exp_q = '{32'sd1, 32'sd2, 32'sd2};
`endif
        chk("pace_out_count", 64'(q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("pace_out%0d", i), (i < q.size()) ? 64'(q[i]) : 64'hDEAD, 64'(exp_q[i]));
        end

`ifndef IIR2_CTRL_WARMUP_EN
        // Simultaneous soft_clear and offered sample in S_IDLE
        to_cyc(t2 + 18);
        chk("idle_busy", 64'(busy), 64'd0);
        s_if.valid = 1'b1;
        soft_clear = 1'b1;
        #1;
        chk("sim_s_ready", 64'(s_if.ready), 64'd0);
        tick(1);
        chk("sim_no_issue", 64'(f_data_in_valid), 64'd0);
        chk("sim_f_clear",  64'(f_clear),         64'd1);
        soft_clear = 1'b0;
        s_if.valid = 1'b0;
        tick(1);
        chk("sim_clear_end", 64'(f_clear),    64'd0);
        chk("sim_ready",     64'(s_if.ready), 64'd1);

        // Backpressure
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        wait_issue("bp_issue1", tb);
        to_cyc(tb + 2);
        chk("bp_m_valid", 64'(m_if.valid), 64'd1);
        chk("bp_m_data",  64'(m_if.data),  64'd1);
        to_cyc(tb + 20);
        chk("bp_hold_valid", 64'(m_if.valid),      64'd1);
        chk("bp_hold_data",  64'(m_if.data),       64'd1);
        chk("bp_s_ready",    64'(s_if.ready),      64'd0);
        chk("bp_no_issue",   64'(f_data_in_valid), 64'd0);
        m_if.ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(s_if.ready), 64'd1);
        tick(1);
        chk("bp_issue2",   64'(f_data_in_valid), 64'd1);
        chk("bp_drained",  64'(m_if.valid),      64'd0);
        tb2 = cyc;
        s_if.valid = 1'b0;
        to_cyc(tb2 + 2);
        chk("bp_out2_valid", 64'(m_if.valid), 64'd1);
        chk("bp_out2_data",  64'(m_if.data),  64'd2);

        // Coefficient update in the middle of a gap
        s_if.valid = 1'b1;
        wait_issue("cu_issue", tc);
        to_cyc(tc + 5);
        cfg_coeff_a1 = 10'h080;
        coeff_update = 1'b1;
        tick(1);
        coeff_update = 1'b0;
        to_cyc(tc + 17);
        chk("cu_a1_before", 64'(f_coeff_a1), 64'd0);
        chk("cu_ready_low", 64'(s_if.ready), 64'd0);
        to_cyc(tc + 18);
        chk("cu_a1_applied",  64'(f_coeff_a1),      64'h080);
        chk("cu_no_issue",    64'(f_data_in_valid), 64'd0);
        tick(1);
        chk("cu_issue_after", 64'(f_data_in_valid), 64'd1);
        td = cyc;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;

        // Soft clear in the middle of a gap drops the pending output
        to_cyc(td + 7);
        chk("clr_pending", 64'(m_if.valid), 64'd1);
        soft_clear = 1'b1;
        tick(1);
        soft_clear = 1'b0;
        chk("clr_f_clear", 64'(f_clear),    64'd1);
        chk("clr_s_ready", 64'(s_if.ready), 64'd0);
        tick(1);
        chk("clr_f_clear_end", 64'(f_clear),    64'd0);
        chk("clr_m_dropped",   64'(m_if.valid), 64'd0);
        chk("clr_ready",       64'(s_if.ready), 64'd1);
        m_if.ready = 1'b1;
        s_if.valid = 1'b1;
        tick(1);
        chk("clr_issue", 64'(f_data_in_valid), 64'd1);
        s_if.valid = 1'b0;
        to_cyc(td + 12);
        chk("clr_out_valid", 64'(m_if.valid), 64'd1);
        chk("clr_out_data",  64'(m_if.data),  64'd1);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
